// File: rtl/dbg_io_pkg.sv
// -----------------------------------------------------------------------------
// dbg_io_pkg
// Shared types and constants for the DE2 debug I/O controller:
//   mode_t     - tick generator mode (single-step or free-run)
//   SEG_BLANK  - active-low seven-segment pattern with every segment off
//   SEG_GLYPH  - active-low glyphs for 0-F (bit0 = a ... bit6 = g)
//   seg_encode - nibble to glyph lookup
// -----------------------------------------------------------------------------
package dbg_io_pkg;

  typedef enum logic {
    MODE_STEP = 1'b0,
    MODE_RUN  = 1'b1
  } mode_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Standard hex glyphs; b and d are lowercase so they differ from 8 and 0.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    return SEG_GLYPH[nib];
  endfunction

endpackage

// File: rtl/dbg_io_ctrl_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Conditions one asynchronous active-low pushbutton.
//   clk_50  - board clock
//   reset   - synchronous, active-low
//   key_n   - raw pushbutton level (0 = pressed)
//   press   - one-cycle pulse when the accepted level goes 1 -> 0
// The raw level goes through a 2-flop synchroniser. A new level is accepted
// only after DEBOUNCE_CYCLES consecutive synchronised samples disagree with
// the currently accepted level. Releases are accepted silently.
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_50,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            meta_q;
  logic            sync_q;
  logic            level_q, level_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    // Any sample that agrees with the accepted level restarts the count,
    // so only an unbroken run of disagreeing samples can flip the level.
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q;
        press_d = ~sync_q;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (!reset) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      meta_q  <= key_n;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/dbg_io_ctrl.sv
// -----------------------------------------------------------------------------
// dbg_io_ctrl
// Board-level debug controller for the multicycle CPU on the DE2.
//   clk_50     - 50 MHz board clock; the only clock domain
//   reset      - synchronous, active-low
//   run_mode   - slide switch, async; 1 = free-run, 0 = single-step
//   step_key   - pushbutton, async, active-low; one tick per press in STEP
//   page_key   - pushbutton, async, active-low; advances the display page
//   probe      - NUM_CH 32-bit channels, channel k at [32k+31:32k]
//   cpu_tick   - one-cycle CPU clock-enable pulse
//   tick_count - cpu_tick pulses since reset, wrapping
//   page_idx   - channel currently shown on the display
//   hex        - eight active-low digits, digit d at [7d+6:7d]
// The CPU is advanced by an enable pulse, never by a derived clock.
// -----------------------------------------------------------------------------
module dbg_io_ctrl
  import dbg_io_pkg::*;
#(
  parameter int DIV_MAX         = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int NUM_CH          = 4,
  parameter int CNT_W           = 16
) (
  input  logic                      clk_50,
  input  logic                      reset,
  input  logic                      run_mode,
  input  logic                      step_key,
  input  logic                      page_key,
  input  logic [NUM_CH*32-1:0]      probe,
  output logic                      cpu_tick,
  output logic [CNT_W-1:0]          tick_count,
  output logic [$clog2(NUM_CH)-1:0] page_idx,
  output logic [55:0]               hex
);

  localparam int DIV_W  = $clog2(DIV_MAX);
  localparam int PAGE_W = $clog2(NUM_CH);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV_MAX - 1);
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(NUM_CH - 1);

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic run_meta_q;
  logic run_sync_q;
  logic step_press;
  logic page_press;

  always_ff @(posedge clk_50) begin
    if (!reset) begin
      run_meta_q <= 1'b0;
      run_sync_q <= 1'b0;
    end else begin
      run_meta_q <= run_mode;
      run_sync_q <= run_meta_q;
    end
  end

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_key (
    .clk_50 (clk_50),
    .reset  (reset),
    .key_n  (step_key),
    .press  (step_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_page_key (
    .clk_50 (clk_50),
    .reset  (reset),
    .key_n  (page_key),
    .press  (page_press)
  );

  // ---------------------------------------------------------------------------
  // Tick generator FSM
  // ---------------------------------------------------------------------------
  mode_t              mode_q, mode_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               step_tick_q, step_tick_d;
  logic               mode_change;
  logic               run_tick;

  always_comb begin
    mode_change = (mode_t'(run_sync_q) != mode_q);
    mode_d      = mode_t'(run_sync_q);
    div_d       = '0;
    step_tick_d = 1'b0;
    run_tick    = 1'b0;
    // A cycle in which the synchronised switch disagrees with the current
    // mode is the transition cycle: divider clears, nothing ticks, and a
    // step press landing here is dropped.
    if (!mode_change) begin
      case (mode_q)
        MODE_RUN: begin
          if (div_q == DIV_LAST) begin
            run_tick = 1'b1;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        MODE_STEP: begin
          step_tick_d = step_press;
        end
        default: ;
      endcase
    end
    // A queued step tick is also withheld if the mode starts changing in
    // the cycle it would have been issued.
    cpu_tick = run_tick | (step_tick_q & ~mode_change);
  end

  always_ff @(posedge clk_50) begin
    if (!reset) begin
      mode_q      <= MODE_STEP;
      div_q       <= '0;
      step_tick_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      div_q       <= div_d;
      step_tick_q <= step_tick_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Tick counter and page select
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PAGE_W-1:0] page_q, page_d;

  always_comb begin
    count_d = cpu_tick ? count_q + CNT_W'(1) : count_q;
    page_d  = page_q;
    if (page_press) begin
      page_d = (page_q == PAGE_LAST) ? '0 : page_q + PAGE_W'(1);
    end
  end

  always_ff @(posedge clk_50) begin
    if (!reset) begin
      count_q <= '0;
      page_q  <= '0;
    end else begin
      count_q <= count_d;
      page_q  <= page_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Display: registered glyphs of the selected channel
  // ---------------------------------------------------------------------------
  logic [31:0] chan;
  logic [55:0] hex_q, hex_d;

  always_comb begin
    chan = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (page_q == PAGE_W'(k)) chan = probe[32*k +: 32];
    end
    hex_d = {8{SEG_BLANK}};
    for (int d = 0; d < 8; d++) begin
      hex_d[7*d +: 7] = seg_encode(chan[4*d +: 4]);
    end
  end

  always_ff @(posedge clk_50) begin
    if (!reset) begin
      hex_q <= {8{SEG_BLANK}};
    end else begin
      hex_q <= hex_d;
    end
  end

  assign tick_count = count_q;
  assign page_idx   = page_q;
  assign hex        = hex_q;

endmodule
